// File: rtl/arbitro_arduino.sv
// Arbitrates memory-playback and button-feedback notes onto a single buzzer output.
// Optional macro ARBITRO_PREEMPCAO_EN lets a button note preempt a playing memory note.
module arbitro_arduino #(
    parameter int DURACAO = 50000000,
    parameter int PAUSA   = 5000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       req_mem,
    input  logic [6:0] nota_mem,
    input  logic       req_bot,
    input  logic [6:0] nota_bot,
    output logic       ack_mem,
    output logic       ack_bot,
    output logic [2:0] arduino_out,
    output logic       ocupado,
    output logic [2:0] db_estado
);

    localparam int MAX_CICLOS = (DURACAO > PAUSA) ? DURACAO : PAUSA;
    localparam int CW         = (MAX_CICLOS > 1) ? $clog2(MAX_CICLOS) : 1;

    localparam logic [CW-1:0] CARGA_TOCA  = CW'(DURACAO - 1);
    localparam logic [CW-1:0] CARGA_PAUSA = CW'(PAUSA - 1);

`ifdef ARBITRO_PREEMPCAO_EN
    localparam bit PREEMPCAO_EN = 1'b1;
`else
    localparam bit PREEMPCAO_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        ST_OCIOSO = 3'd0,
        ST_TOCA   = 3'd1,
        ST_PAUSA  = 3'd2
    } estado_t;

    estado_t       estado;
    logic [CW-1:0] cnt;
    logic          ultimo_bot;    // 1 = bot was granted last, so mem wins the next tie
    logic          servindo_bot;

    logic ponto_arb;
    logic concede_mem;
    logic concede_bot;
    logic preempcao;

    // Code is 1 + index of the lowest set bit; scanning downwards lets the lowest bit win.
    function automatic logic [2:0] codigo_nota(input logic [6:0] nota);
        logic [2:0] codigo;
        codigo = 3'd0;
        for (int i = 6; i >= 0; i--) begin
            if (nota[i]) codigo = 3'(i + 1);
        end
        return codigo;
    endfunction

    // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        ponto_arb   = (estado == ST_OCIOSO) || ((estado == ST_PAUSA) && (cnt == '0));
        preempcao   = PREEMPCAO_EN && (estado == ST_TOCA) && !servindo_bot && req_bot;
        concede_bot = ponto_arb && req_bot && (!req_mem || !ultimo_bot);
        concede_mem = ponto_arb && req_mem && !concede_bot;
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clock) begin
        // NOTE: only control state is reset; there is no memory array here to leave uninitialised.
        if (!reset) begin
            estado       <= ST_OCIOSO;
            cnt          <= '0;
            arduino_out  <= 3'd0;
            ack_mem      <= 1'b0;
            ack_bot      <= 1'b0;
            ocupado      <= 1'b0;
            ultimo_bot   <= 1'b0;
            servindo_bot <= 1'b0;
        end else begin
            ack_mem <= 1'b0;
            ack_bot <= 1'b0;

            if (preempcao || concede_bot) begin
                estado       <= ST_TOCA;
                ack_bot      <= 1'b1;
                arduino_out  <= codigo_nota(nota_bot);
                cnt          <= CARGA_TOCA;
                ocupado      <= 1'b1;
                ultimo_bot   <= 1'b1;
                servindo_bot <= 1'b1;
            end else if (concede_mem) begin
                estado       <= ST_TOCA;
                ack_mem      <= 1'b1;
                arduino_out  <= codigo_nota(nota_mem);
                cnt          <= CARGA_TOCA;
                ocupado      <= 1'b1;
                ultimo_bot   <= 1'b0;
                servindo_bot <= 1'b0;
            end else begin
                unique case (estado)
                    ST_OCIOSO: begin
                        arduino_out <= 3'd0;
                        ocupado     <= 1'b0;
                    end
                    ST_TOCA: begin
                        if (cnt == '0) begin
                            estado      <= ST_PAUSA;
                            arduino_out <= 3'd0;
                            cnt         <= CARGA_PAUSA;
                        end else begin
                            cnt <= cnt - CW'(1);
                        end
                    end
                    ST_PAUSA: begin
                        // Reaching zero here with no grant means nobody is waiting.
                        if (cnt == '0) begin
                            estado  <= ST_OCIOSO;
                            ocupado <= 1'b0;
                        end else begin
                            cnt <= cnt - CW'(1);
                        end
                    end
                    default: begin
                        estado      <= ST_OCIOSO;
                        arduino_out <= 3'd0;
                        ocupado     <= 1'b0;
                        cnt         <= '0;
                    end
                endcase
            end
        end
    end

    assign db_estado = estado;

endmodule

// File: tb/tb_arbitro_arduino.sv
// Scoreboard bench for arbitro_arduino: a time-offset reference model predicts every
// output cycle, a monitor on the falling edge compares against the DUT.
module tb_arbitro_arduino;

    localparam int D = 4;
    localparam int P = 2;

`ifdef ARBITRO_PREEMPCAO_EN
    localparam bit PRE = 1'b1;
`else
    localparam bit PRE = 1'b0;
`endif

    logic       clock;
    logic       reset;
    logic       req_mem;
    logic [6:0] nota_mem;
    logic       req_bot;
    logic [6:0] nota_bot;
    logic       ack_mem;
    logic       ack_bot;
    logic [2:0] arduino_out;
    logic       ocupado;
    logic [2:0] db_estado;

    arbitro_arduino #(.DURACAO(D), .PAUSA(P)) dut (
        .clock      (clock),
        .reset      (reset),
        .req_mem    (req_mem),
        .nota_mem   (nota_mem),
        .req_bot    (req_bot),
        .nota_bot   (nota_bot),
        .ack_mem    (ack_mem),
        .ack_bot    (ack_bot),
        .arduino_out(arduino_out),
        .ocupado    (ocupado),
        .db_estado  (db_estado)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic [2:0] out;
        logic       am;
        logic       ab;
        logic       oc;
        logic [2:0] db;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state: whether a note slot is active and how many cycles into it we are.
    bit m_busy     = 1'b0;
    int m_t        = 0;
    int m_code     = 0;
    bit m_ptr_bot  = 1'b0;
    bit m_serv_bot = 1'b0;
    bit m_ack_mem  = 1'b0;
    bit m_ack_bot  = 1'b0;

    bit auto_drop = 1'b0;

    function automatic int ref_code(input logic [6:0] n);
        int v;
        v = int'(n);
        if (v == 0) return 0;
        return $clog2(v & -v) + 1;
    endfunction

    function automatic logic [6:0] rand_note();
        case ($urandom_range(0, 3))
            0:       return 7'd0;
            1:       return 7'(1 << $urandom_range(0, 6));
            default: return 7'($urandom);
        endcase
    endfunction

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    always @(posedge clock) begin
        bit   arb;
        bit   pre;
        bit   gm;
        bit   gb;
        exp_t e;
        m_ack_mem = 1'b0;
        m_ack_bot = 1'b0;
        if (!reset) begin
            m_busy     = 1'b0;
            m_t        = 0;
            m_ptr_bot  = 1'b0;
            m_serv_bot = 1'b0;
        end else begin
            arb = !m_busy || (m_t == D + P - 1);
            pre = PRE && m_busy && (m_t < D) && !m_serv_bot && req_bot;
            gm  = 1'b0;
            gb  = 1'b0;
            if (pre) gb = 1'b1;
            else if (arb) begin
                if (req_bot && req_mem) begin
                    if (m_ptr_bot) gm = 1'b1;
                    else           gb = 1'b1;
                end else if (req_bot) gb = 1'b1;
                else if (req_mem)     gm = 1'b1;
            end
            if (gb) begin
                m_code = ref_code(nota_bot); m_ptr_bot = 1'b1; m_serv_bot = 1'b1;
                m_busy = 1'b1; m_t = 0; m_ack_bot = 1'b1;
            end else if (gm) begin
                m_code = ref_code(nota_mem); m_ptr_bot = 1'b0; m_serv_bot = 1'b0;
                m_busy = 1'b1; m_t = 0; m_ack_mem = 1'b1;
            end else if (arb) begin
                m_busy = 1'b0;
            end else begin
                m_t++;
            end
        end
        e.out = (m_busy && m_t < D) ? 3'(m_code) : 3'd0;
        e.am  = m_ack_mem;
        e.ab  = m_ack_bot;
        e.oc  = m_busy;
        e.db  = !m_busy ? 3'd0 : (m_t < D) ? 3'd1 : 3'd2;
        q.push_back(e);
    end

    always @(negedge clock) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            check("arduino_out", int'(arduino_out), int'(e.out));
            check("ack_mem",     int'(ack_mem),     int'(e.am));
            check("ack_bot",     int'(ack_bot),     int'(e.ab));
            check("ocupado",     int'(ocupado),     int'(e.oc));
            check("db_estado",   int'(db_estado),   int'(e.db));
            check("acks_exclusive", int'(ack_mem & ack_bot), 0);
        end
    end

    task automatic step();
        @(negedge clock);
        if (auto_drop) begin
            if (m_ack_mem) req_mem = 1'b0;
            if (m_ack_bot) req_bot = 1'b0;
        end
    endtask

    initial begin
        reset    = 1'b0;
        req_mem  = 1'b0;
        req_bot  = 1'b0;
        nota_mem = 7'd0;
        nota_bot = 7'd0;

        // Reset with no requests, then idle.
        repeat (2) step();
        reset = 1'b1;
        repeat (3) step();

        // Single memory note, code 3.
        auto_drop = 1'b1;
        req_mem = 1'b1; nota_mem = 7'b0000100;
        repeat (10) step();

        // Both held through reset release: bot wins first, then alternation.
        auto_drop = 1'b0;
        reset = 1'b0;
        req_mem = 1'b1; nota_mem = 7'b0010000;
        req_bot = 1'b1; nota_bot = 7'b0000010;
        repeat (2) step();
        reset = 1'b1;
        repeat (26) step();
        req_mem = 1'b0; req_bot = 1'b0;
        repeat (8) step();

        // Multi-bit note and silent note.
        auto_drop = 1'b1;
        req_bot = 1'b1; nota_bot = 7'b1010000;
        repeat (8) step();
        req_bot = 1'b1; nota_bot = 7'b0000000;
        repeat (8) step();

        // Reset during the second TOCA cycle.
        req_mem = 1'b1; nota_mem = 7'b0001000;
        repeat (2) step();
        reset = 1'b0;
        step();
        reset = 1'b1;
        repeat (3) step();

        // Bot request while a memory note plays (preempts only with the macro).
        req_mem = 1'b1; nota_mem = 7'b0000010;
        repeat (2) step();
        req_bot = 1'b1; nota_bot = 7'b0000001;
        repeat (14) step();

        // Randomized traffic with occasional resets and abandoned requests.
        auto_drop = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clock);
            if (m_ack_mem) req_mem = ($urandom_range(0, 3) == 0);
            else if (!req_mem) begin
                if ($urandom_range(0, 3) == 0) begin
                    req_mem = 1'b1; nota_mem = rand_note();
                end
            end else if ($urandom_range(0, 49) == 0) req_mem = 1'b0;
            if (m_ack_bot) req_bot = ($urandom_range(0, 3) == 0);
            else if (!req_bot) begin
                if ($urandom_range(0, 5) == 0) begin
                    req_bot = 1'b1; nota_bot = rand_note();
                end
            end else if ($urandom_range(0, 49) == 0) req_bot = 1'b0;
            if ($urandom_range(0, 7) == 0) nota_mem = rand_note();
            if ($urandom_range(0, 7) == 0) nota_bot = rand_note();
            reset = ($urandom_range(0, 299) != 0);
        end

        req_mem = 1'b0; req_bot = 1'b0; reset = 1'b1;
        repeat (10) step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
